// File: rtl/showcase0_result_capture_if.sv
// Result-capture port bundle: showcase0 result inputs, sample stream out, and status.
// The slave modport is the capture block's view; the master modport is the driver/consumer side.
interface showcase0_result_capture_if #(
    parameter int DEPTH = 4
);
    logic                     en;
    logic [31:0]              c;
    logic [7:0]               g;
    logic [5:0]               cmp;
    logic [45:0]              out_data;
    logic                     out_vld;
    logic                     out_rd;
    logic [$clog2(DEPTH):0]   level;
    logic                     overflow;
    logic                     clr_overflow;
`ifdef SHOWCASE0_CAPTURE_STATS_EN
    logic [15:0]              drop_cnt;

    modport slave (
        input  en, c, g, cmp, out_rd, clr_overflow,
        output out_data, out_vld, level, overflow, drop_cnt
    );
    modport master (
        output en, c, g, cmp, out_rd, clr_overflow,
        input  out_data, out_vld, level, overflow, drop_cnt
    );
`else
    modport slave (
        input  en, c, g, cmp, out_rd, clr_overflow,
        output out_data, out_vld, level, overflow
    );
    modport master (
        output en, c, g, cmp, out_rd, clr_overflow,
        input  out_data, out_vld, level, overflow
    );
`endif
endinterface

// File: rtl/showcase0_result_capture.sv
// Captures {cmp,g,c} every SAMPLE_DIV enabled cycles into a DEPTH-entry fall-through FIFO.
// Latency: sample captured at edge N is on out_data/out_vld from cycle N+1.
// Backpressure: out_vld/out_rd handshake; a capture into a full FIFO with no pop is dropped and
// sets sticky overflow. Optional drop counter under SHOWCASE0_CAPTURE_STATS_EN.
module showcase0_result_capture #(
    parameter int DEPTH      = 4,
    parameter int SAMPLE_DIV = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    showcase0_result_capture_if.slave    cap_if
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    typedef struct packed {
        logic [5:0]  cmp;
        logic [7:0]  g;
        logic [31:0] c;
    } sample_t;

    sample_t         mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [LW-1:0]   level_q;
    logic [CW-1:0]   div_cnt;
    logic            ovf_q;

    logic capture;
    logic full;
    logic pop;
    logic push;
    logic drop;

    assign capture = cap_if.en && (div_cnt == CW'(SAMPLE_DIV - 1));
    assign full    = (level_q == LW'(DEPTH));
    assign pop     = (level_q != '0) && cap_if.out_rd;
    // A pop on the same edge frees the slot the capture needs, so a full FIFO only drops without one.
    assign push    = capture && (!full || pop);
    assign drop    = capture && full && !pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (cap_if.en) begin
            div_cnt <= capture ? '0 : div_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= '{cmp: cap_if.cmp, g: cap_if.g, c: cap_if.c};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
        end else if (cap_if.clr_overflow) begin
            ovf_q <= 1'b0;
        end
    end

`ifdef SHOWCASE0_CAPTURE_STATS_EN
    logic [15:0] drop_cnt_q;

    // Clear and drop on the same edge leaves exactly the one new drop counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
        end else if (drop) begin
            if (cap_if.clr_overflow) begin
                drop_cnt_q <= 16'd1;
            end else if (drop_cnt_q != 16'hFFFF) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
        end else if (cap_if.clr_overflow) begin
            drop_cnt_q <= '0;
        end
    end

    assign cap_if.drop_cnt = drop_cnt_q;
`endif

    assign cap_if.out_data = mem[rd_ptr];
    assign cap_if.out_vld  = (level_q != '0);
    assign cap_if.level    = level_q;
    assign cap_if.overflow = ovf_q;

endmodule

// File: tb/tb_showcase0_result_capture.sv
// Bench for showcase0_result_capture: queue model compared every cycle plus directed literal checks.
module tb_showcase0_result_capture;
    localparam int DEPTH = 4;
    localparam int DIV_A = 1;
    localparam int DIV_B = 3;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    showcase0_result_capture_if #(.DEPTH(DEPTH)) a ();
    showcase0_result_capture_if #(.DEPTH(DEPTH)) b ();

    showcase0_result_capture #(.DEPTH(DEPTH), .SAMPLE_DIV(DIV_A)) u_a (.clk(clk), .rst_n(rst_n), .cap_if(a));
    showcase0_result_capture #(.DEPTH(DEPTH), .SAMPLE_DIV(DIV_B)) u_b (.clk(clk), .rst_n(rst_n), .cap_if(b));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    // Model of instance a: a plain queue of samples, overflow flag, drop counter.
    logic [45:0] q[$];
    bit          m_ovf;
    int          m_drops;
    int          m_en_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_ovf    = 1'b0;
            m_drops  = 0;
            m_en_cnt = 0;
        end else begin
            bit did_pop;
            bit cap;
            bit dropped;
            did_pop = (q.size() != 0) && a.out_rd;
            cap     = a.en && ((m_en_cnt % DIV_A) == DIV_A - 1);
            dropped = 1'b0;
            if (a.en) m_en_cnt++;
            if (did_pop) void'(q.pop_front());
            if (cap) begin
                if (q.size() < DEPTH) q.push_back({a.cmp, a.g, a.c});
                else dropped = 1'b1;
            end
            if (dropped) m_ovf = 1'b1;
            else if (a.clr_overflow) m_ovf = 1'b0;
            if (dropped) m_drops = a.clr_overflow ? 1 : ((m_drops < 65535) ? m_drops + 1 : 65535);
            else if (a.clr_overflow) m_drops = 0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("model out_vld", 64'(a.out_vld), 64'(q.size() != 0));
            chk("model level", 64'(a.level), 64'(q.size()));
            chk("model overflow", 64'(a.overflow), 64'(m_ovf));
            if (q.size() != 0) chk("model out_data", 64'(a.out_data), 64'(q[0]));
`ifdef SHOWCASE0_CAPTURE_STATS_EN
            chk("model drop_cnt", 64'(a.drop_cnt), 64'(m_drops));
`endif
        end
    end

    initial begin
        int exp4[4];
        int exp5[3];
        exp4 = '{21, 22, 23, 99};
        exp5 = '{2, 7, 10};
        rst_n = 1'b0;
        a.en = 0; a.c = '0; a.g = '0; a.cmp = '0; a.out_rd = 0; a.clr_overflow = 0;
        b.en = 0; b.c = '0; b.g = '0; b.cmp = '0; b.out_rd = 0; b.clr_overflow = 0;
        #3;
        chk("reset out_vld", 64'(a.out_vld), 64'd0);
        chk("reset level", 64'(a.level), 64'd0);
        chk("reset overflow", 64'(a.overflow), 64'd0);
        chk("reset out_data", 64'(a.out_data), 64'd0);
        cyc();
        cyc();
        rst_n = 1'b1;

        // Three captures with no consumer, then drain in order.
        a.en = 1;
        for (int i = 1; i <= 3; i++) begin
            a.c = 32'(i); a.g = 8'(8'hA0 + i); a.cmp = 6'(i * 5);
            cyc();
        end
        a.en = 0;
        chk("t2 level", 64'(a.level), 64'd3);
        chk("t2 head c", 64'(a.out_data[31:0]), 64'd1);
        chk("t2 head g/cmp", 64'(a.out_data[45:32]), 64'({6'd5, 8'hA1}));
        a.out_rd = 1;
        for (int i = 1; i <= 3; i++) begin
            chk("t2 pop c", 64'(a.out_data[31:0]), 64'(i));
            cyc();
        end
        chk("t2 empty", 64'(a.out_vld), 64'd0);
        a.out_rd = 0;

        // Six captures into a 4-deep FIFO: two drops.
        a.en = 1;
        for (int i = 0; i < 6; i++) begin
            a.c = 32'(10 + i); a.g = 8'(i); a.cmp = 6'(63 - i);
            cyc();
            chk("t3 level", 64'(a.level), 64'((i + 1 < 4) ? i + 1 : 4));
            chk("t3 overflow", 64'(a.overflow), 64'(i >= 4));
        end
        a.en = 0;
`ifdef SHOWCASE0_CAPTURE_STATS_EN
        chk("t3 drop_cnt", 64'(a.drop_cnt), 64'd2);
`endif
        a.out_rd = 1;
        for (int i = 0; i < 4; i++) begin
            chk("t3 readback", 64'(a.out_data[31:0]), 64'(10 + i));
            cyc();
        end
        a.out_rd = 0;
        chk("t3 drained", 64'(a.out_vld), 64'd0);

        // Refill, then clear on the same edge as a drop: set wins.
        a.en = 1;
        for (int i = 0; i < 4; i++) begin
            a.c = 32'(20 + i);
            cyc();
        end
        a.c = 32'd24; a.clr_overflow = 1;
        cyc();
        chk("t6 set wins", 64'(a.overflow), 64'd1);
        chk("t6 level", 64'(a.level), 64'd4);
`ifdef SHOWCASE0_CAPTURE_STATS_EN
        chk("t6 drop_cnt one", 64'(a.drop_cnt), 64'd1);
`endif
        a.en = 0;
        cyc();
        chk("t6 cleared", 64'(a.overflow), 64'd0);
`ifdef SHOWCASE0_CAPTURE_STATS_EN
        chk("t6 drop_cnt zero", 64'(a.drop_cnt), 64'd0);
`endif
        a.clr_overflow = 0;

        // Full FIFO: pop and capture on the same edge, nothing lost.
        a.en = 1; a.c = 32'd99; a.out_rd = 1;
        cyc();
        a.en = 0;
        chk("t4 level", 64'(a.level), 64'd4);
        chk("t4 overflow", 64'(a.overflow), 64'd0);
        for (int i = 0; i < 4; i++) begin
            chk("t4 order", 64'(a.out_data[31:0]), 64'(exp4[i]));
            cyc();
        end
        chk("t4 drained", 64'(a.out_vld), 64'd0);
        a.out_rd = 0;

        // Asynchronous reset with two entries held.
        a.en = 1; a.c = 32'd30;
        cyc();
        a.c = 32'd31;
        cyc();
        a.en = 0;
        chk("t1 level before", 64'(a.level), 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t1 async vld", 64'(a.out_vld), 64'd0);
        chk("t1 async level", 64'(a.level), 64'd0);
        chk("t1 async ovf", 64'(a.overflow), 64'd0);
        cyc();
        rst_n = 1'b1;
        a.out_rd = 1;
        cyc();
        cyc();
        chk("t1 nothing emitted", 64'(a.out_vld), 64'd0);
        a.out_rd = 0;

        // Decimation by 3 on instance b, with an enable gap.
        for (int i = 0; i <= 10; i++) begin
            b.en = (i <= 3) || (i >= 6);
            b.c = 32'(i);
            cyc();
        end
        b.en = 0;
        chk("t5 level", 64'(b.level), 64'd3);
        b.out_rd = 1;
        for (int i = 0; i < 3; i++) begin
            chk("t5 capture", 64'(b.out_data[31:0]), 64'(exp5[i]));
            cyc();
        end
        chk("t5 drained", 64'(b.out_vld), 64'd0);
        b.out_rd = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
